// File: rtl/uart_rx_if.sv
// Serial-line and byte-delivery signals of the 8N1 receiver.
// slave is the receiver side; master is the pin driver / byte consumer.
interface uart_rx_if;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  modport master (output rx, input data, valid, frame_err, busy);
  modport slave  (input rx, output data, valid, frame_err, busy);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver, 16x oversampling, single-cycle valid / framing-error strobes.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling at phases 7/8/9.
module uart_rx #(
  parameter int FREQUENCY_IN = 100_000_000,
  parameter int BAUD_RATE    = 9600
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave line
);

  localparam int DIV   = FREQUENCY_IN / (BAUD_RATE * 16);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  // A decision is taken on the tick that advances phase into 8 (or 9 with majority).
`ifdef UART_RX_MAJORITY_EN
  localparam logic [3:0] DECIDE_PHASE = 4'd8;
`else
  localparam logic [3:0] DECIDE_PHASE = 4'd7;
`endif

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic             rx_meta;
  logic             rx_s;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       phase;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             tick;
  logic             decide;
  logic             sample;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= line.rx;
      rx_s    <= rx_meta;
    end
  end

  assign tick   = (state != IDLE) && (div_cnt == DIV_LAST);
  assign decide = tick && (phase == DECIDE_PHASE);

`ifdef UART_RX_MAJORITY_EN
  logic s7;
  logic s8;

  always_ff @(posedge clk) begin
    if (rst) begin
      s7 <= 1'b1;
      s8 <= 1'b1;
    end else if (tick) begin
      if (phase == 4'd6) s7 <= rx_s;
      if (phase == 4'd7) s8 <= rx_s;
    end
  end

  assign sample = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);
`else
  assign sample = rx_s;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      div_cnt        <= '0;
      phase          <= '0;
      bit_idx        <= '0;
      shift          <= '0;
      line.data      <= '0;
      line.valid     <= 1'b0;
      line.frame_err <= 1'b0;
      line.busy      <= 1'b0;
    end else begin
      // NOTE: strobes default low every cycle so any set below lasts exactly one clock.
      line.valid     <= 1'b0;
      line.frame_err <= 1'b0;

      if (state == IDLE || tick) div_cnt <= '0;
      else                       div_cnt <= div_cnt + DIV_W'(1);

      if (tick) phase <= phase + 4'd1;

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state     <= START;
            phase     <= '0;
            bit_idx   <= '0;
            line.busy <= 1'b1;
          end
        end
        START: begin
          if (decide) begin
            if (!sample) begin
              state <= DATA;
            end else begin
              state     <= IDLE;
              line.busy <= 1'b0;
            end
          end
        end
        DATA: begin
          if (decide) begin
            shift <= {sample, shift[7:1]};
            if (bit_idx == 3'd7) state <= STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end
        end
        STOP: begin
          // Leaving at mid-stop keeps a back-to-back start edge catchable.
          if (decide) begin
            state     <= IDLE;
            line.busy <= 1'b0;
            if (sample) begin
              line.data  <= shift;
              line.valid <= 1'b1;
            end else begin
              line.frame_err <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
